// File: rtl/aes_key_expand_seq.sv
// aes_key_expand_seq: iterative AES key schedule, one 32-bit word per clock, full schedule held after completion
module aes_key_expand_seq #(
  parameter int NR = 10,
  parameter int NK = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [32*NK-1:0]        key_in,
  output logic                    busy,
  output logic                    done,
  output logic                    key_valid,
  output logic [128*(NR+1)-1:0]   ExpandedKeys
);
  localparam int NW = 4*(NR+1);
  localparam logic [5:0] NK6  = 6'(NK);
  localparam logic [5:0] LAST = 6'(NW-1);
  typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_DONE} state_t;
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xtime(x);
    end
    return p;
  endfunction
  // S-box computed as GF(2^8) inverse (x^254 by repeated squaring) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, r;
    sq = x;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction
  state_t      state_q;
  logic [5:0]  cnt_q;
  logic [7:0]  rcon_q, rcon_d;
  logic        busy_q, done_q, kv_q;
  logic [31:0] w_q [NW];
  logic [31:0] prev, t, word_d;
  logic        rot, sub_only;
  always_comb begin
    prev     = w_q[cnt_q - 6'd1];
    rot      = (cnt_q % NK6) == 6'd0;
    sub_only = (NK > 6) && ((cnt_q % NK6) == 6'd4);
    t        = rot ? sub_word({prev[23:0], prev[31:24]}) ^ {rcon_q, 24'h0} :
               sub_only ? sub_word(prev) : prev;
    word_d   = w_q[cnt_q - NK6] ^ t;
    rcon_d   = xtime(rcon_q);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rcon_q  <= 8'h01;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      kv_q    <= 1'b0;
      for (int i = 0; i < NW; i++) w_q[i] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          for (int i = 0; i < NK; i++) w_q[i] <= key_in[32*(NK-i)-1 -: 32];
          cnt_q   <= NK6;
          rcon_q  <= 8'h01;
          kv_q    <= 1'b0;
          busy_q  <= 1'b1;
          state_q <= ST_EXPAND;
        end
        ST_EXPAND: begin
          w_q[cnt_q] <= word_d;
          cnt_q      <= cnt_q + 6'd1;
          if (rot) rcon_q <= rcon_d;
          if (cnt_q == LAST) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            kv_q    <= 1'b1;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  for (genvar g = 0; g < NW; g++) begin : g_out
    assign ExpandedKeys[32*(NW-g)-1 -: 32] = w_q[g];
  end
  assign busy      = busy_q;
  assign done      = done_q;
  assign key_valid = kv_q;
endmodule

// File: tb/tb_aes_key_expand_seq.sv
// tb_aes_key_expand_seq: scoreboard bench for AES-128 and AES-256 key expansion against FIPS-197 vectors
module tb_aes_key_expand_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start128 = 1'b0, start256 = 1'b0;
  logic [127:0] key128 = '0;
  logic [255:0] key256 = '0;
  logic busy128, done128, kv128, busy256, done256, kv256;
  logic [1407:0] ek128;
  logic [1919:0] ek256;
  int errors = 0, checks = 0, cyc = 0;
  typedef struct {
    string        tag;
    logic [127:0] first;
    logic [127:0] last;
    int           t0;
    int           lat;
  } exp_t;
  exp_t sb128[$];
  exp_t sb256[$];
  localparam logic [127:0] KA = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] LA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KB = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] LB = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [255:0] K2 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] L2 = 128'hfe4890d1e6188d0b046df344706c631e;
  aes_key_expand_seq #(.NR(10), .NK(4)) dut128 (
    .clk(clk), .reset(rst_n), .start(start128), .key_in(key128),
    .busy(busy128), .done(done128), .key_valid(kv128), .ExpandedKeys(ek128));
  aes_key_expand_seq #(.NR(14), .NK(8)) dut256 (
    .clk(clk), .reset(rst_n), .start(start256), .key_in(key256),
    .busy(busy256), .done(done256), .key_valid(kv256), .ExpandedKeys(ek256));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk) if (rst_n && done128) begin
    if (sb128.size() == 0) check("spurious_done128", done128, 1'b0);
    else begin
      exp_t e;
      e = sb128.pop_front();
      check({e.tag, "_lat"}, 128'(cyc - e.t0), 128'(e.lat));
      check({e.tag, "_first"}, ek128[1407 -: 128], e.first);
      check({e.tag, "_last"}, ek128[127:0], e.last);
      check({e.tag, "_kv"}, kv128, 1'b1);
      check({e.tag, "_busy"}, busy128, 1'b0);
    end
  end
  always @(negedge clk) if (rst_n && done256) begin
    if (sb256.size() == 0) check("spurious_done256", done256, 1'b0);
    else begin
      exp_t e;
      e = sb256.pop_front();
      check({e.tag, "_lat"}, 128'(cyc - e.t0), 128'(e.lat));
      check({e.tag, "_first"}, ek256[1919 -: 128], e.first);
      check({e.tag, "_last"}, ek256[127:0], e.last);
      check({e.tag, "_kv"}, kv256, 1'b1);
    end
  end
  task automatic push128(input string tag, input logic [127:0] k, input logic [127:0] last, input int t0);
    exp_t e;
    e.tag = tag; e.first = k; e.last = last; e.t0 = t0; e.lat = 40;
    sb128.push_back(e);
  endtask
  task automatic go128(input string tag, input logic [127:0] k, input logic [127:0] last);
    @(negedge clk);
    key128 = k;
    start128 = 1'b1;
    push128(tag, k, last, cyc + 1);
    @(negedge clk);
    start128 = 1'b0;
  endtask
  task automatic drain();
    int n;
    n = 0;
    while ((sb128.size() != 0 || sb256.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 128'(sb128.size() + sb256.size()), 128'd0);
    repeat (3) @(negedge clk);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", busy128, 1'b0);
    check("rst_done", done128, 1'b0);
    check("rst_kv", kv128, 1'b0);
    check("rst_ek128", {127'd0, |ek128}, 128'd0);
    check("rst_ek256", {127'd0, |ek256}, 128'd0);
    rst_n = 1'b1;
    go128("t1", KA, LA);
    drain();
    check("t1_w4", ek128[1279 -: 32], 32'ha0fafe17);
    check("t1_hold_kv", kv128, 1'b1);
    @(negedge clk);
    key256 = K2;
    start256 = 1'b1;
    begin
      exp_t e;
      e.tag = "t2"; e.first = K2[255:128]; e.last = L2; e.t0 = cyc + 1; e.lat = 52;
      sb256.push_back(e);
    end
    @(negedge clk);
    start256 = 1'b0;
    drain();
    check("t2_busy_after", busy256, 1'b0);
    go128("t3", KA, LA);
    repeat (4) @(negedge clk);
    start128 = 1'b1;
    key128 = KB;
    @(negedge clk);
    start128 = 1'b0;
    repeat (14) @(negedge clk);
    start128 = 1'b1;
    @(negedge clk);
    start128 = 1'b0;
    drain();
    check("t3_idle", busy128, 1'b0);
    go128("t4", KA, LA);
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    sb128.delete();
    check("t4_busy", busy128, 1'b0);
    check("t4_done", done128, 1'b0);
    check("t4_kv", kv128, 1'b0);
    check("t4_ek", {127'd0, |ek128}, 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    go128("t4b", KA, LA);
    drain();
    go128("t5a", KA, LA);
    begin
      int n;
      n = 0;
      while (!done128 && n < 60) begin
        @(negedge clk);
        n++;
      end
      check("t5_done_seen", done128, 1'b1);
    end
    go128("t5b", KB, LB);
    check("t5_kv_drop", kv128, 1'b0);
    check("t5_busy", busy128, 1'b1);
    drain();
    @(negedge clk);
    key128 = KA;
    start128 = 1'b1;
    push128("t6r0", KA, LA, cyc + 1);
    push128("t6r1", KA, LA, cyc + 43);
    push128("t6r2", KA, LA, cyc + 85);
    repeat (85) @(negedge clk);
    start128 = 1'b0;
    drain();
    check("t6_idle", busy128, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
